hack_boot_loader: RTL and testbench

Boot and program-load controller for the Hack computer. It holds the CPU in reset and streams program words into the writable instruction store (the 32K ROM, built as RAM with a write port). It then releases the CPU to run from address 0. It sits between an external word source (UART/host bridge) and the instruction store, and drives the CPU's reset input.

---
 rtl/hack_pkg.sv | 18 +
 rtl/hack_boot_wr_stage.sv | 40 ++++
 rtl/hack_boot_loader.sv | 100 ++++++++++
 tb/tb_hack_boot_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and sizing constants for the Hack boot/program-load path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hack_pkg;

    localparam int HACK_ADDR_W    = 15;
    localparam int HACK_DATA_W    = 16;
    localparam int HACK_ROM_WORDS = 32768;

    typedef enum logic [2:0] {
        HALT  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } boot_state_e;

endpackage

// File: rtl/hack_boot_wr_stage.sv
// Registered instruction-store write stage with the load address counter.
// Latency: one cycle from accept strobe to rom_wr_en/addr/data.
// Backpressure: none; every accept strobe becomes exactly one write.
module hack_boot_wr_stage
    import hack_pkg::*;
#(
    parameter int ADDR_W = HACK_ADDR_W,
    parameter int DATA_W = HACK_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rom_wr_en,
    output logic [ADDR_W-1:0] rom_wr_addr,
    output logic [DATA_W-1:0] rom_wr_data,
    output logic [ADDR_W:0]   count
);

    // Launch one write per accepted beat; the counter doubles as the word tally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_wr_en   <= 1'b0;
            rom_wr_addr <= '0;
            rom_wr_data <= '0;
            count       <= '0;
        end else begin
            rom_wr_en <= accept;
            if (clear) begin
                count <= '0;
            end else if (accept) begin
                rom_wr_addr <= count[ADDR_W-1:0];
                rom_wr_data <= wr_data;
                count       <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hack_boot_loader.sv
// Holds the Hack CPU in reset, streams program words into the instruction store, then releases it.
// Latency: one cycle from accepted beat to store write; CPU released the cycle after the final write.
// Backpressure: in_ready is high only while loading; overflow or completion drops it immediately.
module hack_boot_loader
    import hack_pkg::*;
#(
    parameter int ADDR_W    = HACK_ADDR_W,
    parameter int DATA_W    = HACK_DATA_W,
    parameter int MAX_WORDS = HACK_ROM_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              rom_wr_en,
    output logic [ADDR_W-1:0] rom_wr_addr,
    output logic [DATA_W-1:0] rom_wr_data,
    output logic              cpu_reset,
    output logic [ADDR_W:0]   loaded_words,
    output logic              busy,
    output logic              error
);

    // Index of the final slot; a non-last beat landing here overflows the store.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MAX_WORDS - 1);

    boot_state_e      state;
    logic             accept;
    logic             start;
    logic             at_last_slot;
    logic [ADDR_W:0]  count;

    assign in_ready     = (state == LOAD);
    assign accept       = in_valid && in_ready;
    // load_start is honoured only when no load is in flight.
    assign start        = load_start && ((state == HALT) || (state == RUN) || (state == ERROR));
    assign at_last_slot = (count == LAST_IDX);
    assign loaded_words = count;

    hack_boot_wr_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_stage (
        .clk         (clk),
        .reset       (reset),
        .clear       (start),
        .accept      (accept),
        .wr_data     (in_data),
        .rom_wr_en   (rom_wr_en),
        .rom_wr_addr (rom_wr_addr),
        .rom_wr_data (rom_wr_data),
        .count       (count)
    );

    // Boot sequencing with registered CPU reset, busy and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HALT;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                HALT, RUN, ERROR: begin
                    if (start) begin
                        state     <= LOAD;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (in_last) begin
                            state <= FLUSH;
                        end else if (at_last_slot) begin
                            state <= ERROR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state     <= RUN;
                    cpu_reset <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= HALT;
                    cpu_reset <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_boot_loader.sv
module tb_hack_boot_loader;

    localparam int AW   = 15;
    localparam int DW   = 16;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          rom_wr_en;
    logic [AW-1:0] rom_wr_addr;
    logic [DW-1:0] rom_wr_data;
    logic          cpu_reset;
    logic [AW:0]   loaded_words;
    logic          busy;
    logic          error;

    int checks = 0;
    int failures = 0;
    bit checking = 0;

    hack_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .rom_wr_en    (rom_wr_en),
        .rom_wr_addr  (rom_wr_addr),
        .rom_wr_data  (rom_wr_data),
        .cpu_reset    (cpu_reset),
        .loaded_words (loaded_words),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the loader is doing, as plain flags and a word tally.
    logic          m_loading = 0, m_flushing = 0, m_running = 0, m_err = 0, m_wr = 0;
    int            m_count = 0;
    int            m_addr = 0;
    logic [DW-1:0] m_data = '0;
    wire m_acc   = m_loading && in_valid;
    wire m_start = load_start && !m_loading && !m_flushing;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_loading <= 0; m_flushing <= 0; m_running <= 0; m_err <= 0;
            m_wr <= 0; m_count <= 0; m_addr <= 0; m_data <= '0;
        end else begin
            m_wr <= m_acc;
            if (m_acc) begin
                m_addr  <= m_count;
                m_data  <= in_data;
                m_count <= m_count + 1;
            end
            if (m_acc && in_last) begin
                m_loading <= 0; m_flushing <= 1;
            end else if (m_acc && m_count == MAXW - 1) begin
                m_loading <= 0; m_err <= 1;
            end
            if (m_flushing) begin
                m_flushing <= 0; m_running <= 1;
            end
            if (m_start) begin
                m_loading <= 1; m_running <= 0; m_err <= 0; m_count <= 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checking && !reset) begin
            chk("cyc_in_ready", in_ready, m_loading);
            chk("cyc_cpu_reset", cpu_reset, !m_running);
            chk("cyc_busy", busy, m_loading || m_flushing);
            chk("cyc_error", error, m_err);
            chk("cyc_loaded_words", loaded_words, m_count);
            chk("cyc_rom_wr_en", rom_wr_en, m_wr);
            if (m_wr) begin
                chk("cyc_rom_wr_addr", rom_wr_addr, m_addr);
                chk("cyc_rom_wr_data", rom_wr_data, m_data);
            end
        end
    end

    // Shadow of the instruction store as seen through the write port.
    logic [DW-1:0] mem [int];
    int wr_count = 0;
    always @(negedge clk) begin
        if (!reset && rom_wr_en === 1'b1) begin
            mem[int'(rom_wr_addr)] = rom_wr_data;
            wr_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit last, input int gap, output bit ok);
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_run(input string name);
        for (int i = 0; i < 20 && cpu_reset !== 1'b0; i++) @(negedge clk);
        chk(name, cpu_reset, 1'b0);
        tick();
    endtask

    task automatic load_three(input int gap, input string tag);
        bit ok;
        logic [DW-1:0] prog [3];
        prog = '{16'h0002, 16'hEC10, 16'h0000};
        mem.delete();
        wr_count = 0;
        pulse_load();
        for (int i = 0; i < 3; i++) begin
            send_beat(prog[i], i == 2, (i == 0) ? 0 : gap, ok);
            chk({tag, "_accept"}, ok, 1'b1);
        end
        wait_run({tag, "_run"});
        chk({tag, "_mem0"}, mem[0], 16'h0002);
        chk({tag, "_mem1"}, mem[1], 16'hEC10);
        chk({tag, "_mem2"}, mem[2], 16'h0000);
        chk({tag, "_wr_count"}, wr_count, 3);
        chk({tag, "_loaded_words"}, loaded_words, 3);
        chk({tag, "_error"}, error, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bit ok;
        // Reset and idle.
        repeat (3) tick();
        reset = 1'b0;
        checking = 1;
        repeat (10) tick();
        @(negedge clk);
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_rom_wr_en", rom_wr_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_loaded_words", loaded_words, 0);
        chk("rst_error", error, 1'b0);
        chk("rst_rom_wr_addr", rom_wr_addr, 0);
        chk("rst_rom_wr_data", rom_wr_data, 0);
        tick();

        // Back-to-back load, then the same load with 2-cycle holes.
        load_three(0, "b2b");
        load_three(2, "gap");

        // Overflow: four non-last beats fill the store, the fifth is refused.
        mem.delete();
        wr_count = 0;
        pulse_load();
        for (int i = 0; i < 4; i++) begin
            send_beat(DW'((i + 1) * 16'h1111), 1'b0, 0, ok);
            chk("ovf_accept", ok, 1'b1);
        end
        @(negedge clk);
        chk("ovf_error", error, 1'b1);
        chk("ovf_in_ready", in_ready, 1'b0);
        chk("ovf_cpu_reset", cpu_reset, 1'b1);
        chk("ovf_last_wr_addr", rom_wr_addr, 3);
        tick();
        send_beat(16'h5555, 1'b0, 0, ok);
        chk("ovf_5th_rejected", ok, 1'b0);
        chk("ovf_wr_count", wr_count, 4);
        chk("ovf_mem3", mem[3], 16'h4444);
        chk("ovf_loaded_words", loaded_words, 4);
        chk("ovf_cpu_reset_held", cpu_reset, 1'b1);
        pulse_load();
        @(negedge clk);
        chk("ovf_error_cleared", error, 1'b0);
        chk("ovf_count_cleared", loaded_words, 0);
        tick();
        send_beat(16'h1234, 1'b1, 0, ok);
        wait_run("ovf_recover_run");

        // Reload from RUN with a single word.
        mem.delete();
        wr_count = 0;
        pulse_load();
        @(negedge clk);
        chk("rl_cpu_reset_rise", cpu_reset, 1'b1);
        tick();
        send_beat(16'h7FFF, 1'b1, 0, ok);
        chk("rl_accept", ok, 1'b1);
        wait_run("rl_run");
        chk("rl_mem0", mem[0], 16'h7FFF);
        chk("rl_wr_count", wr_count, 1);
        chk("rl_loaded_words", loaded_words, 1);

        // Asynchronous reset two beats into a load.
        pulse_load();
        send_beat(16'hAAAA, 1'b0, 0, ok);
        send_beat(16'hBBBB, 1'b0, 0, ok);
        in_valid = 1'b1;
        in_data  = 16'hCCCC;
        #2 reset = 1'b1;
        #1;
        chk("ar_cpu_reset", cpu_reset, 1'b1);
        chk("ar_rom_wr_en", rom_wr_en, 1'b0);
        chk("ar_in_ready", in_ready, 1'b0);
        chk("ar_busy", busy, 1'b0);
        tick();
        reset = 1'b0;
        wr_count = 0;
        repeat (6) tick();
        chk("ar_no_writes", wr_count, 0);
        chk("ar_halt_in_ready", in_ready, 1'b0);
        chk("ar_halt_cpu_reset", cpu_reset, 1'b1);
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
